// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-add multiplier: one partial product per clock on an A:Q pair.
// Start/busy/done handshake matches the restoring divider so controllers can swap them.
module shift_add_mult #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] m, a, q;
   logic             c;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] a_shift, q_shift;
   logic             last_iter;

   // Conditional add that keeps the carry-out as the top bit of the result.
   function automatic logic [WIDTH:0] add_step(input logic             cin,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] addend,
                                               input logic             sel);
      logic [WIDTH-1:0] gated;
      gated = sel ? addend : '0;
      return {cin, acc} + {1'b0, gated};
   endfunction

   always_comb begin
      sum       = add_step(c, a, m, q[0]);
      a_shift   = sum[WIDTH:1];
      q_shift   = {sum[0], q[WIDTH-1:1]};
      last_iter = (count == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m       <= '0;
         a       <= '0;
         q       <= '0;
         c       <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               m     <= multiplicand;
               q     <= multiplier;
               a     <= '0;
               c     <= 1'b0;
               count <= CW'(WIDTH);
            end
            CALC: begin
               // Carry was folded into a_shift; the shift leaves C clear.
               a     <= a_shift;
               q     <= q_shift;
               c     <= 1'b0;
               count <= count - 1'b1;
               if (last_iter) product <= {a_shift, q_shift};
            end
            default: ;
         endcase
      end
   end

endmodule
